sha512_pad_seq: RTL

//  Upstream feeder of the SHA-512 block pipeline. Accepts raw message beats (128 B each, valid/ready) and applies
//  SHA-512 padding plus the 128-bit length field. Emits 1024-bit blocks tagged first/midd/last with message index.

---
 rtl/sha512_pad_seq.sv | 235 +++++++++++++++++++++++
 1 files changed

// File: rtl/sha512_pad_seq.sv
// sha512_pad_seq: SHA-512 message padder and block pacer.
// Turns 128-byte message beats into padded 1024-bit blocks. Successive blocks of one
// message leave exactly SLOT_N cycles apart, so each one meets its chaining hash in
// the downstream round-trip pipeline. That pipeline has no backpressure, so all pacing
// happens here.
module sha512_pad_seq #(
  parameter int DATA_W = 1024,
  parameter int CTRL_W = 3,
  parameter int MSGI_W = 64,
  parameter int SLOT_N = 83,
  parameter int LEN_W  = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_valid,
  output logic              o_ready,
  input  logic [DATA_W-1:0] i_data,
  input  logic              i_sop,
  input  logic              i_eop,
  input  logic [7:0]        i_bytes,
  input  logic [MSGI_W-1:0] i_msgi,
  output logic              o_valid,
  output logic [DATA_W-1:0] o_data,
  output logic [CTRL_W-1:0] o_ctrl,
  output logic [MSGI_W-1:0] o_msgi,
  output logic              o_busy,
  output logic              o_err
);

  localparam int NBYTES = DATA_W / 8;
  localparam int CNT_W  = (SLOT_N > 2) ? $clog2(SLOT_N) : 1;
  localparam logic [CNT_W-1:0]  SLOT_LOAD   = CNT_W'(SLOT_N - 1);
  localparam logic [7:0]        FULL_N      = 8'(NBYTES);
  // Largest tail that still leaves room for the 0x80 marker plus the 16-byte length.
  localparam logic [7:0]        MAX_SHORT   = 8'(NBYTES - 17);
  localparam logic [CTRL_W-1:0] CTRL_FIRST  = CTRL_W'(3'b100);
  localparam logic [CTRL_W-1:0] CTRL_MIDD   = CTRL_W'(3'b010);
  localparam logic [CTRL_W-1:0] CTRL_LAST   = CTRL_W'(3'b001);
  localparam logic [CTRL_W-1:0] CTRL_SINGLE = CTRL_W'(3'b101);

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_PADX,
    S_DRAIN
  } state_t;

  // 128-bit length field: the message bit count. Bits above LEN_W+3 stay zero.
  function automatic logic [127:0] len_field(input logic [LEN_W-1:0] len_bytes);
    return 128'({len_bytes, 3'b000});
  endfunction

  // Keep the first n bytes, put the 0x80 marker at byte n, and zero the rest.
  // Optionally overlay the length field on the low 128 bits.
  function automatic logic [DATA_W-1:0] pad_beat(input logic [DATA_W-1:0] d,
                                                 input logic [7:0]        n,
                                                 input logic              add_len,
                                                 input logic [127:0]      lenf);
    logic [DATA_W-1:0] b;
    b = '0;
    for (int k = 0; k < NBYTES; k++) begin
      if (k < int'(n)) begin
        b[DATA_W-1-8*k -: 8] = d[DATA_W-1-8*k -: 8];
      end else if (k == int'(n)) begin
        b[DATA_W-1-8*k -: 8] = 8'h80;
      end
    end
    if (add_len) begin
      b[127:0] = lenf;
    end
    return b;
  endfunction

  // Trailing pad-only block. It carries the marker only when the last beat was full.
  function automatic logic [DATA_W-1:0] pad_extra(input logic       mark,
                                                  input logic [127:0] lenf);
    logic [DATA_W-1:0] b;
    b = '0;
    b[DATA_W-1 -: 8] = mark ? 8'h80 : 8'h00;
    b[127:0] = lenf;
    return b;
  endfunction

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [LEN_W-1:0]  len_q, len_d;
  logic              pad80_q, pad80_d;
  logic [MSGI_W-1:0] msgi_q, msgi_d;

  logic [7:0]        beat_n;
  logic              short_eop;
  logic              slot_due;
  logic              ready_c;
  logic              take_sop;
  logic              take_cont;
  logic              emit_c;
  logic              err_c;
  logic [DATA_W-1:0] blk_c;
  logic [CTRL_W-1:0] ctrl_c;
  logic [MSGI_W-1:0] msgi_c;

  // A non-eop beat always carries a full 128 bytes. An oversize count is clamped.
  assign beat_n    = !i_eop ? FULL_N : ((i_bytes > FULL_N) ? FULL_N : i_bytes);
  assign short_eop = i_eop && (beat_n <= MAX_SHORT);
  assign slot_due  = (cnt_q == '0);

  assign o_ready = rst && ready_c;
  assign o_busy  = rst && ((state_q == S_WAIT) || (state_q == S_PADX));

  // Next-state, slot pacing, length accumulation and block assembly.
  always_comb begin
    state_d   = state_q;
    cnt_d     = (cnt_q != '0) ? (cnt_q - CNT_W'(1)) : '0;
    len_d     = len_q;
    pad80_d   = pad80_q;
    msgi_d    = msgi_q;
    ready_c   = 1'b0;
    take_sop  = 1'b0;
    take_cont = 1'b0;
    emit_c    = 1'b0;
    err_c     = 1'b0;
    blk_c     = '0;
    ctrl_c    = '0;
    msgi_c    = msgi_q;

    case (state_q)
      S_IDLE: begin
        ready_c = 1'b1;
        if (i_valid) begin
          if (i_sop) begin
            take_sop = 1'b1;
          end else begin
            // A stray continuation: drop it and discard the rest of that message.
            err_c = 1'b1;
            if (!i_eop) begin
              state_d = S_DRAIN;
            end
          end
        end
      end
      S_WAIT: begin
        if (slot_due) begin
          ready_c = 1'b1;
          if (!i_valid) begin
            // The slot would go by empty, so the message can never complete.
            err_c   = 1'b1;
            state_d = S_DRAIN;
          end else if (i_sop) begin
            err_c    = 1'b1;
            take_sop = 1'b1;
          end else begin
            take_cont = 1'b1;
          end
        end
      end
      S_PADX: begin
        if (slot_due) begin
          emit_c  = 1'b1;
          blk_c   = pad_extra(pad80_q, len_field(len_q));
          ctrl_c  = CTRL_LAST;
          state_d = S_IDLE;
        end
      end
      S_DRAIN: begin
        ready_c = 1'b1;
        if (i_valid) begin
          if (i_sop) begin
            take_sop = 1'b1;
          end else if (i_eop) begin
            state_d = S_IDLE;
          end
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    if (take_sop || take_cont) begin
      len_d   = (take_sop ? '0 : len_q) + LEN_W'(beat_n);
      emit_c  = 1'b1;
      blk_c   = pad_beat(i_data, beat_n, short_eop, len_field(len_d));
      cnt_d   = SLOT_LOAD;
      pad80_d = (beat_n == FULL_N);
      if (take_sop) begin
        msgi_d = i_msgi;
        msgi_c = i_msgi;
      end
      if (short_eop) begin
        ctrl_c  = take_sop ? CTRL_SINGLE : CTRL_LAST;
        state_d = S_IDLE;
      end else begin
        ctrl_c  = take_sop ? CTRL_FIRST : CTRL_MIDD;
        state_d = i_eop ? S_PADX : S_WAIT;
      end
    end
  end

  // Control state: FSM, slot counter, running length and per-message context.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      len_q   <= '0;
      pad80_q <= 1'b0;
      msgi_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      len_q   <= len_d;
      pad80_q <= pad80_d;
      msgi_q  <= msgi_d;
    end
  end

  // Output register stage: a block built from a beat taken in cycle T leaves in T+1.
  always_ff @(posedge clk) begin
    if (!rst) begin
      o_valid <= 1'b0;
      o_data  <= '0;
      o_ctrl  <= '0;
      o_msgi  <= '0;
      o_err   <= 1'b0;
    end else begin
      o_valid <= emit_c;
      o_err   <= err_c;
      if (emit_c) begin
        o_data <= blk_c;
        o_ctrl <= ctrl_c;
        o_msgi <= msgi_c;
      end
    end
  end

endmodule
